// File: rtl/rv_pkg.sv
// Shared RV64 pipeline definitions: opcode and load funct3 encodings and the
// writeback state encoding.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        WB_RUN       = 2'd0,
        WB_SQUASH    = 2'd1,
        WB_TRAP_WAIT = 2'd2
    } wb_state_e;

    // Set/clear forms (funct3[1]=1) with rs1=x0 carry a zero mask and only read the CSR.
    function automatic logic csr_writes(input logic [2:0] funct3, input logic [4:0] rs1);
        return !((rs1 == 5'd0) && funct3[1]);
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// WB stage register from the memory stage, plus the stall back towards it.
interface writeback_stage_if #(
    parameter int XLEN = 64
);
    logic            WB_V;
    logic [31:0]     WB_IR;
    logic [XLEN-1:0] WB_NPC;
    logic [XLEN-1:0] WB_ALU_RESULT;
    logic [XLEN-1:0] WB_MEM_RESULT;
    logic [XLEN-1:0] WB_CSRFD;
    logic            WB_PC_MUX;
    logic            WB_ECALL;
    logic            WB_STALL;

    modport master (
        output WB_V, WB_IR, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_CSRFD, WB_PC_MUX, WB_ECALL,
        input  WB_STALL
    );

    modport slave (
        input  WB_V, WB_IR, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_CSRFD, WB_PC_MUX, WB_ECALL,
        output WB_STALL
    );
endinterface

// File: rtl/writeback_stage_load_extend.sv
// Load data extension: right-justified raw load data to a full XLEN register value.
module load_extend
    import rv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] ext
);
    always_comb begin
        ext = raw;
        case (funct3)
            F3_LB:   ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
            F3_LH:   ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
            F3_LW:   ext = {{(XLEN-32){raw[31]}}, raw[31:0]};
            F3_LBU:  ext = {{(XLEN-8){1'b0}}, raw[7:0]};
            F3_LHU:  ext = {{(XLEN-16){1'b0}}, raw[15:0]};
            F3_LWU:  ext = {{(XLEN-32){1'b0}}, raw[31:0]};
            default: ext = raw;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// RV64 writeback: register-file/CSR write, branch redirect with younger-slot squash,
// ECALL trap handshake and retired-instruction counter.
module writeback_stage
    import rv_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int SQUASH_CYCLES = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    writeback_stage_if.slave wb,
    input  logic            TRAP_ACK,
    output logic            RF_WE,
    output logic [4:0]      RF_DR,
    output logic [XLEN-1:0] RF_DATA,
    output logic            CSR_WE,
    output logic [11:0]     CSR_ADDR,
    output logic [XLEN-1:0] CSR_WDATA,
    output logic            REDIRECT,
    output logic [XLEN-1:0] REDIRECT_PC,
    output logic            TRAP_REQ,
    output logic [XLEN-1:0] TRAP_EPC,
    output logic [63:0]     INSTRET
);
    localparam int CNT_W = $clog2(SQUASH_CYCLES + 1);

    wb_state_e        state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] rd_value;
    logic            rd_write;
    logic            csr_write;
    logic            accept;

    assign opcode = wb.WB_IR[6:0];
    assign rd     = wb.WB_IR[11:7];
    assign funct3 = wb.WB_IR[14:12];
    assign rs1    = wb.WB_IR[19:15];

    assign wb.WB_STALL = (state_reg == WB_TRAP_WAIT);
    assign accept      = wb.WB_V && (state_reg == WB_RUN) && !wb.WB_STALL;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3 (funct3),
        .raw    (wb.WB_MEM_RESULT),
        .ext    (load_data)
    );

    always_comb begin
        rd_write  = 1'b0;
        csr_write = 1'b0;
        rd_value  = wb.WB_ALU_RESULT;
        case (opcode)
            OP_LOAD: begin
                rd_write = 1'b1;
                rd_value = load_data;
            end
            OP_JAL, OP_JALR: begin
                rd_write = 1'b1;
                rd_value = wb.WB_NPC;
            end
            OP_SYSTEM: begin
                if (funct3 != 3'b000) begin
                    rd_write  = 1'b1;
                    rd_value  = wb.WB_CSRFD;
                    csr_write = csr_writes(funct3, rs1);
                end
            end
            OP_OP, OP_IMM, OP_OP32, OP_IMM32, OP_LUI, OP_AUIPC: rd_write = 1'b1;
            default: rd_write = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= WB_RUN;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Squash counts only real (valid) younger slots; bubbles do not consume it.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            WB_RUN: begin
                if (accept && wb.WB_ECALL) begin
                    state_next = WB_TRAP_WAIT;
                end else if (accept && wb.WB_PC_MUX) begin
                    state_next = WB_SQUASH;
                    count_next = CNT_W'(SQUASH_CYCLES);
                end
            end
            WB_TRAP_WAIT: begin
                if (TRAP_ACK) begin
                    state_next = WB_SQUASH;
                    count_next = CNT_W'(SQUASH_CYCLES);
                end
            end
            WB_SQUASH: begin
                if (wb.WB_V) begin
                    count_next = count_reg - 1'b1;
                    if (count_reg <= CNT_W'(1)) begin
                        state_next = WB_RUN;
                    end
                end
            end
            default: state_next = WB_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RF_WE       <= 1'b0;
            RF_DR       <= '0;
            RF_DATA     <= '0;
            CSR_WE      <= 1'b0;
            CSR_ADDR    <= '0;
            CSR_WDATA   <= '0;
            REDIRECT    <= 1'b0;
            REDIRECT_PC <= '0;
            TRAP_REQ    <= 1'b0;
            TRAP_EPC    <= '0;
            INSTRET     <= '0;
        end else begin
            RF_WE    <= accept && rd_write && (rd != 5'd0);
            CSR_WE   <= accept && csr_write;
            REDIRECT <= accept && !wb.WB_ECALL && wb.WB_PC_MUX;
            if (accept) begin
                RF_DR     <= rd;
                RF_DATA   <= rd_value;
                CSR_ADDR  <= wb.WB_IR[31:20];
                CSR_WDATA <= wb.WB_ALU_RESULT;
            end
            if (accept && !wb.WB_ECALL && wb.WB_PC_MUX) begin
                REDIRECT_PC <= {wb.WB_ALU_RESULT[XLEN-1:1], 1'b0};
            end
            if (accept && wb.WB_ECALL) begin
                TRAP_REQ <= 1'b1;
                TRAP_EPC <= wb.WB_NPC - XLEN'(4);
            end else if ((state_reg == WB_TRAP_WAIT) && TRAP_ACK) begin
                TRAP_REQ <= 1'b0;
            end
            if (accept && !wb.WB_ECALL) begin
                INSTRET <= INSTRET + 64'd1;
            end
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: loads, ALU/CSR writes, redirect/squash,
// ECALL trap handshake and reset recovery.
module tb_writeback_stage;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        TRAP_ACK;
    logic        RF_WE;
    logic [4:0]  RF_DR;
    logic [63:0] RF_DATA;
    logic        CSR_WE;
    logic [11:0] CSR_ADDR;
    logic [63:0] CSR_WDATA;
    logic        REDIRECT;
    logic [63:0] REDIRECT_PC;
    logic        TRAP_REQ;
    logic [63:0] TRAP_EPC;
    logic [63:0] INSTRET;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_ir = 64'd0;

    writeback_stage_if #(.XLEN(64)) wb_if ();

    writeback_stage #(.XLEN(64), .SQUASH_CYCLES(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .wb          (wb_if),
        .TRAP_ACK    (TRAP_ACK),
        .RF_WE       (RF_WE),
        .RF_DR       (RF_DR),
        .RF_DATA     (RF_DATA),
        .CSR_WE      (CSR_WE),
        .CSR_ADDR    (CSR_ADDR),
        .CSR_WDATA   (CSR_WDATA),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .TRAP_REQ    (TRAP_REQ),
        .TRAP_EPC    (TRAP_EPC),
        .INSTRET     (INSTRET)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ir, input logic [63:0] npc,
                         input logic [63:0] alu, input logic [63:0] mem,
                         input logic [63:0] csrfd, input logic pcmux, input logic ecall);
        wb_if.WB_V          = v;
        wb_if.WB_IR         = ir;
        wb_if.WB_NPC        = npc;
        wb_if.WB_ALU_RESULT = alu;
        wb_if.WB_MEM_RESULT = mem;
        wb_if.WB_CSRFD      = csrfd;
        wb_if.WB_PC_MUX     = pcmux;
        wb_if.WB_ECALL      = ecall;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        TRAP_ACK = 1'b0;
        idle();
        tick();
        tick();
        RESET = 1'b0;
        total++; if (RF_WE !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0b exp=0", RF_WE); end
        total++; if (RF_DATA !== 64'h0) begin bad++; $display("FAIL reset_rf_data got=%h exp=0", RF_DATA); end
        total++; if (REDIRECT !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%0b exp=0", REDIRECT); end
        total++; if (TRAP_REQ !== 1'b0) begin bad++; $display("FAIL reset_trap_req got=%0b exp=0", TRAP_REQ); end
        total++; if (wb_if.WB_STALL !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", wb_if.WB_STALL); end
        total++; if (INSTRET !== 64'h0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", INSTRET); end
        $display("reset: instret=%0d stall=%0b", INSTRET, wb_if.WB_STALL);
    endtask

    task automatic test_load();
        // lb rd=5, raw 0x80
        drive(1'b1, mk(7'b0000011, 3'b000, 5'd5, 5'd2, 12'h0), 64'h104, 64'h0, 64'h80, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd1;
        total++; if (RF_WE !== 1'b1) begin bad++; $display("FAIL lb_we got=%0b exp=1", RF_WE); end
        total++; if (RF_DR !== 5'd5) begin bad++; $display("FAIL lb_dr got=%0d exp=5", RF_DR); end
        total++; if (RF_DATA !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffffffffffff80", RF_DATA); end
        total++; if (INSTRET !== exp_ir) begin bad++; $display("FAIL lb_instret got=%0d exp=%0d", INSTRET, exp_ir); end
        $display("lb: we=%0b dr=%0d data=%h instret=%0d", RF_WE, RF_DR, RF_DATA, INSTRET);
        // lh rd=6, raw 0x8001
        drive(1'b1, mk(7'b0000011, 3'b001, 5'd6, 5'd2, 12'h0), 64'h108, 64'h0, 64'h8001, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd2;
        total++; if (RF_DATA !== 64'hFFFF_FFFF_FFFF_8001) begin bad++; $display("FAIL lh_data got=%h exp=ffffffffffff8001", RF_DATA); end
        $display("lh: data=%h", RF_DATA);
        // lwu rd=5
        drive(1'b1, mk(7'b0000011, 3'b110, 5'd5, 5'd2, 12'h0), 64'h10C, 64'h0, 64'h8000_0000, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd3;
        total++; if (RF_WE !== 1'b1) begin bad++; $display("FAIL lwu_we got=%0b exp=1", RF_WE); end
        total++; if (RF_DATA !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL lwu_data got=%h exp=0000000080000000", RF_DATA); end
        $display("lwu: data=%h", RF_DATA);
        // lwu rd=0: no write but still retires
        drive(1'b1, mk(7'b0000011, 3'b110, 5'd0, 5'd2, 12'h0), 64'h110, 64'h0, 64'h8000_0000, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd4;
        total++; if (RF_WE !== 1'b0) begin bad++; $display("FAIL lwu_x0_we got=%0b exp=0", RF_WE); end
        total++; if (INSTRET !== exp_ir) begin bad++; $display("FAIL lwu_x0_instret got=%0d exp=%0d", INSTRET, exp_ir); end
        $display("lwu x0: we=%0b instret=%0d", RF_WE, INSTRET);
        // ld rd=8, full 64 bits
        drive(1'b1, mk(7'b0000011, 3'b011, 5'd8, 5'd2, 12'h0), 64'h114, 64'h0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd5;
        total++; if (RF_DATA !== 64'h1234_5678_9ABC_DEF0) begin bad++; $display("FAIL ld_data got=%h exp=123456789abcdef0", RF_DATA); end
        $display("ld: data=%h", RF_DATA);
        idle();
        tick();
        total++; if (RF_WE !== 1'b0) begin bad++; $display("FAIL bubble_we got=%0b exp=0", RF_WE); end
    endtask

    task automatic test_alu_csr();
        drive(1'b1, mk(7'b0110011, 3'b000, 5'd7, 5'd1, 12'h0), 64'h204, 64'hDEAD, 64'h0, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd6;
        total++; if (RF_WE !== 1'b1 || RF_DR !== 5'd7) begin bad++; $display("FAIL add_we_dr got=%0b/%0d exp=1/7", RF_WE, RF_DR); end
        total++; if (RF_DATA !== 64'hDEAD) begin bad++; $display("FAIL add_data got=%h exp=dead", RF_DATA); end
        $display("add: dr=%0d data=%h", RF_DR, RF_DATA);
        // csrrw rd=3, rs1=4, csr 0x300
        drive(1'b1, mk(7'b1110011, 3'b001, 5'd3, 5'd4, 12'h300), 64'h208, 64'h22, 64'h0, 64'h11, 1'b0, 1'b0);
        tick(); exp_ir = 64'd7;
        total++; if (RF_DATA !== 64'h11) begin bad++; $display("FAIL csrrw_data got=%h exp=11", RF_DATA); end
        total++; if (CSR_WE !== 1'b1) begin bad++; $display("FAIL csrrw_we got=%0b exp=1", CSR_WE); end
        total++; if (CSR_ADDR !== 12'h300) begin bad++; $display("FAIL csrrw_addr got=%h exp=300", CSR_ADDR); end
        total++; if (CSR_WDATA !== 64'h22) begin bad++; $display("FAIL csrrw_wdata got=%h exp=22", CSR_WDATA); end
        $display("csrrw: rd_data=%h csr_we=%0b addr=%h wdata=%h", RF_DATA, CSR_WE, CSR_ADDR, CSR_WDATA);
        // csrrs rd=9, rs1=0: read only
        drive(1'b1, mk(7'b1110011, 3'b010, 5'd9, 5'd0, 12'h341), 64'h20C, 64'h0, 64'h0, 64'h77, 1'b0, 1'b0);
        tick(); exp_ir = 64'd8;
        total++; if (CSR_WE !== 1'b0) begin bad++; $display("FAIL csrrs_x0_we got=%0b exp=0", CSR_WE); end
        total++; if (RF_WE !== 1'b1 || RF_DATA !== 64'h77) begin bad++; $display("FAIL csrrs_x0_rd got=%0b/%h exp=1/77", RF_WE, RF_DATA); end
        $display("csrrs x0: csr_we=%0b rd_data=%h", CSR_WE, RF_DATA);
        // store: no rd write, still retires
        drive(1'b1, mk(7'b0100011, 3'b011, 5'd10, 5'd1, 12'h0), 64'h210, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd9;
        total++; if (RF_WE !== 1'b0 || CSR_WE !== 1'b0) begin bad++; $display("FAIL store_we got=%0b/%0b exp=0/0", RF_WE, CSR_WE); end
        total++; if (INSTRET !== exp_ir) begin bad++; $display("FAIL store_instret got=%0d exp=%0d", INSTRET, exp_ir); end
        $display("store: we=%0b instret=%0d", RF_WE, INSTRET);
        idle();
        tick();
    endtask

    task automatic test_jal_squash();
        drive(1'b1, mk(7'b1101111, 3'b000, 5'd1, 5'd0, 12'h0), 64'h1004, 64'h2000, 64'h0, 64'h0, 1'b1, 1'b0);
        tick(); exp_ir = 64'd10;
        total++; if (RF_WE !== 1'b1 || RF_DATA !== 64'h1004) begin bad++; $display("FAIL jal_rd got=%0b/%h exp=1/1004", RF_WE, RF_DATA); end
        total++; if (REDIRECT !== 1'b1 || REDIRECT_PC !== 64'h2000) begin bad++; $display("FAIL jal_redirect got=%0b/%h exp=1/2000", REDIRECT, REDIRECT_PC); end
        total++; if (INSTRET !== exp_ir) begin bad++; $display("FAIL jal_instret got=%0d exp=%0d", INSTRET, exp_ir); end
        $display("jal: rd_data=%h redirect=%0b pc=%h", RF_DATA, REDIRECT, REDIRECT_PC);
        idle();
        tick();
        total++; if (REDIRECT !== 1'b0) begin bad++; $display("FAIL jal_pulse got=%0b exp=0", REDIRECT); end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                idle();
                tick();
            end
            drive(1'b1, mk(7'b0110011, 3'b000, 5'd9, 5'd1, 12'h0), 64'h2004, 64'h99, 64'h0, 64'h0, 1'b0, 1'b0);
            tick();
            total++; if (RF_WE !== 1'b0 || INSTRET !== exp_ir) begin bad++; $display("FAIL jal_squash%0d got=%0b/%0d exp=0/%0d", i, RF_WE, INSTRET, exp_ir); end
            $display("jal squash slot %0d: we=%0b instret=%0d", i, RF_WE, INSTRET);
        end
        drive(1'b1, mk(7'b0110011, 3'b000, 5'd9, 5'd1, 12'h0), 64'h2004, 64'h55, 64'h0, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd11;
        total++; if (RF_WE !== 1'b1 || RF_DATA !== 64'h55) begin bad++; $display("FAIL jal_after got=%0b/%h exp=1/55", RF_WE, RF_DATA); end
        total++; if (INSTRET !== exp_ir) begin bad++; $display("FAIL jal_after_instret got=%0d exp=%0d", INSTRET, exp_ir); end
        $display("after squash: we=%0b data=%h instret=%0d", RF_WE, RF_DATA, INSTRET);
        idle();
        tick();
    endtask

    task automatic test_branch();
        drive(1'b1, mk(7'b1100011, 3'b000, 5'd4, 5'd1, 12'h0), 64'h3004, 64'h4001, 64'h0, 64'h0, 1'b1, 1'b0);
        tick(); exp_ir = 64'd12;
        total++; if (RF_WE !== 1'b0) begin bad++; $display("FAIL br_we got=%0b exp=0", RF_WE); end
        total++; if (REDIRECT !== 1'b1 || REDIRECT_PC !== 64'h4000) begin bad++; $display("FAIL br_redirect got=%0b/%h exp=1/4000", REDIRECT, REDIRECT_PC); end
        $display("branch: redirect=%0b pc=%h", REDIRECT, REDIRECT_PC);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(7'b0110011, 3'b000, 5'd9, 5'd1, 12'h0), 64'h4004, 64'h1, 64'h0, 64'h0, 1'b1, 1'b0);
            tick();
            total++; if (RF_WE !== 1'b0 || REDIRECT !== 1'b0 || INSTRET !== exp_ir) begin bad++; $display("FAIL br_squash%0d got=%0b/%0b/%0d exp=0/0/%0d", i, RF_WE, REDIRECT, INSTRET, exp_ir); end
        end
        drive(1'b1, mk(7'b0110011, 3'b000, 5'd9, 5'd1, 12'h0), 64'h4004, 64'h66, 64'h0, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd13;
        total++; if (RF_WE !== 1'b1 || INSTRET !== exp_ir) begin bad++; $display("FAIL br_after got=%0b/%0d exp=1/%0d", RF_WE, INSTRET, exp_ir); end
        $display("after branch squash: we=%0b instret=%0d", RF_WE, INSTRET);
        idle();
        tick();
    endtask

    task automatic test_ecall();
        // PC_MUX also set: ECALL must win
        drive(1'b1, 32'h0000_0073, 64'h3008, 64'h5000, 64'h0, 64'h0, 1'b1, 1'b1);
        tick();
        total++; if (TRAP_REQ !== 1'b1 || TRAP_EPC !== 64'h3004) begin bad++; $display("FAIL ecall_trap got=%0b/%h exp=1/3004", TRAP_REQ, TRAP_EPC); end
        total++; if (wb_if.WB_STALL !== 1'b1) begin bad++; $display("FAIL ecall_stall got=%0b exp=1", wb_if.WB_STALL); end
        total++; if (REDIRECT !== 1'b0 || INSTRET !== exp_ir) begin bad++; $display("FAIL ecall_prio got=%0b/%0d exp=0/%0d", REDIRECT, INSTRET, exp_ir); end
        $display("ecall: trap_req=%0b epc=%h stall=%0b", TRAP_REQ, TRAP_EPC, wb_if.WB_STALL);
        drive(1'b1, mk(7'b0110011, 3'b000, 5'd9, 5'd1, 12'h0), 64'h300C, 64'h1, 64'h0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (TRAP_REQ !== 1'b1 || wb_if.WB_STALL !== 1'b1 || RF_WE !== 1'b0) begin bad++; $display("FAIL trap_hold%0d got=%0b/%0b/%0b exp=1/1/0", i, TRAP_REQ, wb_if.WB_STALL, RF_WE); end
        end
        TRAP_ACK = 1'b1;
        tick();
        TRAP_ACK = 1'b0;
        total++; if (TRAP_REQ !== 1'b0 || wb_if.WB_STALL !== 1'b0) begin bad++; $display("FAIL trap_ack got=%0b/%0b exp=0/0", TRAP_REQ, wb_if.WB_STALL); end
        $display("trap ack: trap_req=%0b stall=%0b", TRAP_REQ, wb_if.WB_STALL);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (RF_WE !== 1'b0 || INSTRET !== exp_ir) begin bad++; $display("FAIL trap_squash%0d got=%0b/%0d exp=0/%0d", i, RF_WE, INSTRET, exp_ir); end
        end
        drive(1'b1, mk(7'b0110011, 3'b000, 5'd9, 5'd1, 12'h0), 64'h300C, 64'h77, 64'h0, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd14;
        total++; if (RF_WE !== 1'b1 || INSTRET !== exp_ir) begin bad++; $display("FAIL trap_after got=%0b/%0d exp=1/%0d", RF_WE, INSTRET, exp_ir); end
        $display("after trap: we=%0b instret=%0d", RF_WE, INSTRET);
        idle();
        tick();
    endtask

    task automatic test_ack_early();
        // ACK already high while in RUN is ignored; held into TRAP_WAIT it clears on the next edge
        TRAP_ACK = 1'b1;
        drive(1'b1, 32'h0000_0073, 64'h5008, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        tick();
        idle();
        total++; if (TRAP_REQ !== 1'b1 || TRAP_EPC !== 64'h5004) begin bad++; $display("FAIL early_ack_req got=%0b/%h exp=1/5004", TRAP_REQ, TRAP_EPC); end
        tick();
        TRAP_ACK = 1'b0;
        total++; if (TRAP_REQ !== 1'b0 || wb_if.WB_STALL !== 1'b0) begin bad++; $display("FAIL early_ack_clear got=%0b/%0b exp=0/0", TRAP_REQ, wb_if.WB_STALL); end
        $display("ack early: trap_req=%0b stall=%0b", TRAP_REQ, wb_if.WB_STALL);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(7'b0110011, 3'b000, 5'd9, 5'd1, 12'h0), 64'h6004, 64'h1, 64'h0, 64'h0, 1'b0, 1'b0);
            tick();
        end
        total++; if (INSTRET !== exp_ir) begin bad++; $display("FAIL early_ack_squash got=%0d exp=%0d", INSTRET, exp_ir); end
        drive(1'b1, mk(7'b0110011, 3'b000, 5'd9, 5'd1, 12'h0), 64'h6004, 64'h2, 64'h0, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd15;
        total++; if (INSTRET !== exp_ir) begin bad++; $display("FAIL early_ack_after got=%0d exp=%0d", INSTRET, exp_ir); end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_trap();
        drive(1'b1, 32'h0000_0073, 64'h7008, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        tick();
        idle();
        total++; if (TRAP_REQ !== 1'b1) begin bad++; $display("FAIL rst_trap_pre got=%0b exp=1", TRAP_REQ); end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        exp_ir = 64'd0;
        total++; if (TRAP_REQ !== 1'b0 || wb_if.WB_STALL !== 1'b0) begin bad++; $display("FAIL rst_trap_clear got=%0b/%0b exp=0/0", TRAP_REQ, wb_if.WB_STALL); end
        total++; if (INSTRET !== 64'd0 || REDIRECT !== 1'b0) begin bad++; $display("FAIL rst_trap_state got=%0d/%0b exp=0/0", INSTRET, REDIRECT); end
        $display("reset mid-trap: trap_req=%0b stall=%0b instret=%0d", TRAP_REQ, wb_if.WB_STALL, INSTRET);
        drive(1'b1, mk(7'b0110011, 3'b000, 5'd4, 5'd1, 12'h0), 64'h0, 64'hABC, 64'h0, 64'h0, 1'b0, 1'b0);
        tick(); exp_ir = 64'd1;
        total++; if (RF_WE !== 1'b1 || RF_DR !== 5'd4 || RF_DATA !== 64'hABC) begin bad++; $display("FAIL rst_add got=%0b/%0d/%h exp=1/4/abc", RF_WE, RF_DR, RF_DATA); end
        total++; if (INSTRET !== exp_ir) begin bad++; $display("FAIL rst_add_instret got=%0d exp=%0d", INSTRET, exp_ir); end
        $display("add after reset: we=%0b data=%h instret=%0d", RF_WE, RF_DATA, INSTRET);
        idle();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load();
        test_alu_csr();
        test_jal_squash();
        test_branch();
        test_ecall();
        test_ack_early();
        test_reset_mid_trap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
